// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if: operand/result bundle for the registered ripple-carry adder
interface ripple_carry_adder_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Overflow;
    logic         out_valid;

    modport master (
        output in_valid, A, B, Cin,
        input  Sum, Cout, Overflow, out_valid
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output Sum, Cout, Overflow, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: N full-adder cells in a true ripple chain feeding one result register
module ripple_carry_adder #(
    parameter int N = 8
) (
    input logic           clk,
    input logic           rst_n,
    ripple_carry_adder_if.slave bus
);
    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic [N-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    logic         r_valid;

    assign w_c[0] = bus.Cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign w_s[i]   = bus.A[i] ^ bus.B[i] ^ w_c[i];
        assign w_c[i+1] = (bus.A[i] & bus.B[i]) | (w_c[i] & (bus.A[i] ^ bus.B[i]));
    end

    // Result fields load only on valid, so idle (possibly X) operands never reach them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[N];
                r_ovf  <= w_c[N] ^ w_c[N-1];
            end
        end
    end

    assign bus.Sum       = r_sum;
    assign bus.Cout      = r_cout;
    assign bus.Overflow  = r_ovf;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed and back-to-back checks of the adder at N = 1, 8 and 16
module tb_ripple_carry_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.N(1))  b1 ();
    ripple_carry_adder_if #(.N(8))  b8 ();
    ripple_carry_adder_if #(.N(16)) b16 ();

    ripple_carry_adder #(.N(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    ripple_carry_adder #(.N(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    ripple_carry_adder #(.N(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    // Golden model: returns {overflow, cout, sum[15:0]} for a w-bit add
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin);
        int u, sa, sb, t;
        logic [15:0] s;
        u  = int'(a) + int'(b) + int'(cin);
        sa = a[w-1] ? int'(a) - (1 << w) : int'(a);
        sb = b[w-1] ? int'(b) - (1 << w) : int'(b);
        t  = sa + sb + int'(cin);
        s  = 16'(u & ((1 << w) - 1));
        return {(t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1))), 1'((u >> w) & 1), s};
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        b8.in_valid = 1'b1;
        b8.A = a;
        b8.B = b;
        b8.Cin = cin;
        @(negedge clk);
        b8.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        b1.in_valid = 0; b1.A = 0; b1.B = 0; b1.Cin = 0;
        b8.in_valid = 1; b8.A = 8'h12; b8.B = 8'h34; b8.Cin = 1;
        b16.in_valid = 0; b16.A = 0; b16.B = 0; b16.Cin = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== 11'h0) begin
            n_err++;
            $display("FAIL reset8: got sum=%h cout=%b ovf=%b vld=%b, want all 0", b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
        end
        n_vec++;
        if (b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0 || b16.Sum !== 16'h0) begin
            n_err++;
            $display("FAIL reset1_16: got vld1=%b vld16=%b sum16=%h, want 0", b1.out_valid, b16.out_valid, b16.Sum);
        end
        b8.in_valid = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive8(8'h0F, 8'h01, 1'b0);
        n_vec++;
        if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== {8'h10, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL add_0f_01: got sum=%h cout=%b ovf=%b vld=%b, want 10 0 0 1", b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta [3] = '{8'hFF, 8'hAA, 8'h00};
        logic [7:0] tb [3] = '{8'h01, 8'h55, 8'h00};
        logic       tc [3] = '{1'b0, 1'b1, 1'b0};
        logic       tco[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive8(ta[i], tb[i], tc[i]);
            n_vec++;
            if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== {8'h00, tco[i], 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL carry_%0d: got sum=%h cout=%b ovf=%b vld=%b, want 00 %b 0 1", i, b8.Sum, b8.Cout, b8.Overflow, b8.out_valid, tco[i]);
            end
        end
    endtask

    task automatic test_overflow();
        drive8(8'h7F, 8'h01, 1'b0);
        n_vec++;
        if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== {8'h80, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_7f_01: got sum=%h cout=%b ovf=%b vld=%b, want 80 0 1 1", b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
        end
        drive8(8'h80, 8'h80, 1'b0);
        n_vec++;
        if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_80_80: got sum=%h cout=%b ovf=%b vld=%b, want 00 1 1 1", b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
        end
    endtask

    task automatic test_hold_reset();
        drive8(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            b8.A = (i == 1) ? 8'hxx : 8'($urandom);
            b8.B = 8'($urandom);
            b8.Cin = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (b8.Sum !== 8'h10 || b8.out_valid !== 1'b0 || b8.Cout !== 1'b0 || b8.Overflow !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: got sum=%h cout=%b ovf=%b vld=%b, want 10 0 0 0", i, b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
            end
        end
        drive8(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        b8.in_valid = 1'b1;
        b8.A = 8'hFF;
        b8.B = 8'h01;
        b8.Cin = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({b8.Sum, b8.Cout, b8.Overflow, b8.out_valid} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_over_valid: got sum=%h cout=%b ovf=%b vld=%b, want all 0", b8.Sum, b8.Cout, b8.Overflow, b8.out_valid);
        end
        b8.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e1, e8, e16;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_vec++;
                if (b1.out_valid !== 1'b1 || {b1.Overflow, b1.Cout, b1.Sum} !== {e1[17:16], e1[0]}) begin
                    n_err++;
                    $display("FAIL b2b_n1_%0d: got ovf=%b cout=%b sum=%b vld=%b, want %b %b %b 1", i, b1.Overflow, b1.Cout, b1.Sum, b1.out_valid, e1[17], e1[16], e1[0]);
                end
                n_vec++;
                if (b8.out_valid !== 1'b1 || {b8.Overflow, b8.Cout, b8.Sum} !== {e8[17:16], e8[7:0]}) begin
                    n_err++;
                    $display("FAIL b2b_n8_%0d: got ovf=%b cout=%b sum=%h vld=%b, want %b %b %h 1", i, b8.Overflow, b8.Cout, b8.Sum, b8.out_valid, e8[17], e8[16], e8[7:0]);
                end
                n_vec++;
                if (b16.out_valid !== 1'b1 || {b16.Overflow, b16.Cout, b16.Sum} !== e16) begin
                    n_err++;
                    $display("FAIL b2b_n16_%0d: got ovf=%b cout=%b sum=%h vld=%b, want %b %b %h 1", i, b16.Overflow, b16.Cout, b16.Sum, b16.out_valid, e16[17], e16[16], e16[15:0]);
                end
            end
            if (i < 1000) begin
                b1.in_valid = 1; b1.A = 1'($urandom); b1.B = 1'($urandom); b1.Cin = 1'($urandom);
                b8.in_valid = 1; b8.A = 8'($urandom); b8.B = 8'($urandom); b8.Cin = 1'($urandom);
                b16.in_valid = 1; b16.A = 16'($urandom); b16.B = 16'($urandom); b16.Cin = 1'($urandom);
                e1  = model(1, {15'd0, b1.A}, {15'd0, b1.B}, b1.Cin);
                e8  = model(8, {8'd0, b8.A}, {8'd0, b8.B}, b8.Cin);
                e16 = model(16, b16.A, b16.B, b16.Cin);
            end else begin
                b1.in_valid = 0;
                b8.in_valid = 0;
                b16.in_valid = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_overflow();
        test_hold_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised N-bit binary adder built as a true ripple-carry chain of N full-adder cells: Sum = A + B + Cin, with carry-out and signed-overflow flags.
- One registered output stage with a valid qualifier makes it a single-cycle arithmetic leaf usable inside clocked datapaths (ALU, accumulator, address increment).
- Reference implementation for carry-propagation and timing studies, so no lookahead or synthesis `+` operator shortcuts are allowed in the carry path.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands on A/B/Cin are valid this cycle.
- A  input  N  operand A, unsigned or two's complement.
- B  input  N  operand B, unsigned or two's complement.
- Cin  input  1  carry into bit 0.
- Sum  output  N  registered sum bits, (A + B + Cin) mod 2^N.
- Cout  output  1  registered carry out of bit N-1 (unsigned overflow).
- Overflow  output  1  registered signed overflow, c[N] XOR c[N-1].
- out_valid  output  1  registered; Sum/Cout/Overflow hold a new result.

Behaviour:
- Carry datapath:
  - c[0] = Cin.
  - For i = 0..N-1: s[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - Instantiate N full-adder cells through a generate loop. No carry-lookahead, carry-select or `+` operator on the carry path.
- Flags:
  - Cout = c[N].
  - Overflow = c[N] ^ c[N-1]; for N = 1, c[N-1] is Cin.
- Register stage, all updates on the rising clk edge:
  - rst_n = 0 at an edge: Sum = 0, Cout = 0, Overflow = 0, out_valid = 0. Reset takes priority over in_valid, and operands presented in that cycle are discarded.
  - rst_n = 1, in_valid = 1: Sum, Cout and Overflow load the combinational results of the current A/B/Cin; out_valid = 1.
  - rst_n = 1, in_valid = 0: Sum, Cout and Overflow hold their previous values; out_valid = 0.
- Latency and throughput:
  - Latency is exactly 1 cycle from the in_valid edge to out_valid.
  - Full throughput: one new operation per cycle, back-to-back valid inputs allowed.
  - No backpressure and no ready signal.
- Outputs never change other than at a clock edge, and there is no combinational path from inputs to outputs.
- Wrap-around: a sum of 2^N or more wraps modulo 2^N with Cout = 1. An all-ones operand plus 1 gives Sum = 0, Cout = 1.
- X/Z on inputs while in_valid = 0 must not propagate into held outputs.
- Deassertion of rst_n takes effect at the next edge. The first valid result can appear on the edge at which rst_n = 1 and in_valid = 1.

Test Plan (N = 8; each check one cycle after the in_valid edge):
- A = 0x0F, B = 0x01, Cin = 0 -> Sum = 0x10, Cout = 0, Overflow = 0, out_valid = 1.
- A = 0xFF, B = 0x01, Cin = 0 -> Sum = 0x00, Cout = 1, Overflow = 0 (full carry ripple through all bits).
- A = 0xAA, B = 0x55, Cin = 1 -> Sum = 0x00, Cout = 1, Overflow = 0. Then A = 0x00, B = 0x00, Cin = 0 -> Sum = 0x00, Cout = 0.
- Signed overflow:
  - A = 0x7F, B = 0x01, Cin = 0 -> Sum = 0x80, Cout = 0, Overflow = 1.
  - A = 0x80, B = 0x80, Cin = 0 -> Sum = 0x00, Cout = 1, Overflow = 1.
- Hold and reset:
  - After a valid result 0x10, drop in_valid for 3 cycles with random A/B -> Sum stays 0x10, out_valid = 0.
  - Assert rst_n = 0 together with in_valid = 1 -> next edge Sum = 0, Cout = 0, Overflow = 0, out_valid = 0.
- Back-to-back random stream: 1000 consecutive valid operand sets, each result checked against the (A + B + Cin) golden model one cycle later; repeat the stream with N = 1 and N = 16.
